// File: rtl/spi_frame_rx.sv
// SPI slave frame receiver running entirely in the system clock domain.
// Oversamples sck/sdi/load, assembles a FRAME_W-bit frame and hands it off via valid/ack.
module spi_frame_rx #(
  parameter int WORD_W      = 16,
  parameter int NUM_WORDS   = 2,
  parameter int CPOL        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          sck,
  input  logic                          sdi,
  input  logic                          load,
  output logic [WORD_W*NUM_WORDS-1:0]   data,
  output logic                          data_valid,
  input  logic                          data_ack,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int FRAME_W = WORD_W * NUM_WORDS;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, HOLD} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sdi_sync_q, load_sync_q, settle_q;
  logic                   sck_d_q, load_d_q;
  logic                   armed_q, armed_d;
  logic [FRAME_W-1:0]     sr_q, sr_d;
  logic [FRAME_W-1:0]     data_q, data_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   extra_q, extra_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;

  logic sck_s, sdi_s, load_s, settled, sample, load_rise;

  assign sck_s   = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s   = sdi_sync_q[SYNC_STAGES-1];
  assign load_s  = load_sync_q[SYNC_STAGES-1];
  assign settled = settle_q[SYNC_STAGES-1];
  assign sample  = (CPOL == 0) ? (sck_s & ~sck_d_q) : (~sck_s & sck_d_q);

  // The sync chain reads 0 straight out of reset; a frame may only start once load
  // has genuinely been seen low, so a transfer already running at release is skipped.
  assign armed_d   = armed_q | (settled & ~load_s);
  assign load_rise = armed_q & load_s & ~load_d_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync_q  <= '0;
      sdi_sync_q  <= '0;
      load_sync_q <= '0;
      settle_q    <= '0;
      sck_d_q     <= 1'b0;
      load_d_q    <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], load};
      settle_q    <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      sck_d_q     <= sck_s;
      load_d_q    <= load_s;
      armed_q     <= armed_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      extra_q     <= 1'b0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      extra_q     <= extra_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    extra_d     = extra_q;
    valid_d     = valid_q & ~data_ack;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_rise) begin
          sr_d    = '0;
          cnt_d   = '0;
          extra_d = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!load_s) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (sample) begin
          sr_d  = {sr_q[FRAME_W-2:0], sdi_s};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = COMMIT;
        end
      end
      COMMIT: begin
        // An ack landing in this cycle retires the old frame, so it is not an overrun.
        data_d    = sr_q;
        overrun_d = valid_q & ~data_ack;
        valid_d   = 1'b1;
        state_d   = HOLD;
      end
      HOLD: begin
        if (sample) extra_d = 1'b1;
        if (!load_s) begin
          frame_err_d = extra_q | sample;
          extra_d     = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign busy       = (state_q == SHIFT) || (state_q == HOLD);
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Bench for spi_frame_rx: directed vector table, hand sequences for reset/mode 2,
// and randomized frames scored against a frame-level reference model.
module tb_spi_frame_rx;

  localparam int FW = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic sck0 = 1'b0, sdi0 = 1'b0, load0 = 1'b0, ack0 = 1'b0;
  logic [31:0] data0;
  logic valid0, busy0, fe0, ov0;

  logic sck1 = 1'b1, sdi1 = 1'b0, load1 = 1'b0, ack1 = 1'b0;
  logic [31:0] data1;
  logic valid1, busy1, fe1, ov1;

  spi_frame_rx #(.WORD_W(16), .NUM_WORDS(2), .CPOL(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset_n(reset_n), .sck(sck0), .sdi(sdi0), .load(load0),
    .data(data0), .data_valid(valid0), .data_ack(ack0), .busy(busy0),
    .frame_err(fe0), .overrun(ov0)
  );

  spi_frame_rx #(.WORD_W(8), .NUM_WORDS(4), .CPOL(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .sck(sck1), .sdi(sdi1), .load(load1),
    .data(data1), .data_valid(valid1), .data_ack(ack1), .busy(busy1),
    .frame_err(fe1), .overrun(ov1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int fe_cnt0 = 0, ov_cnt0 = 0, fe_cnt1 = 0, ov_cnt1 = 0;

  always @(negedge clk) begin
    if (fe0) fe_cnt0++;
    if (ov0) ov_cnt0++;
    if (fe1) fe_cnt1++;
    if (ov1) ov_cnt1++;
  end

  typedef struct {
    logic [63:0] bits;
    int          nbits;
    bit          ack_before;
    bit          ack_commit;
    logic [31:0] exp_data;
    bit          exp_valid;
    int          exp_fe;
    int          exp_ov;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input int u, input logic s, input logic d, input logic l);
    if (u == 0) begin sck0 = s; sdi0 = d; load0 = l; end
    else        begin sck1 = s; sdi1 = d; load1 = l; end
  endtask

  task automatic set_ack(input int u, input logic a);
    if (u == 0) ack0 = a; else ack1 = a;
  endtask

  task automatic pulse_ack(input int u);
    @(negedge clk); set_ack(u, 1'b1);
    @(negedge clk); set_ack(u, 1'b0);
  endtask

  // sck at clk/8; data set up half a period before the sample edge.
  task automatic clock_bits(input int u, input logic [63:0] bits, input int n, input bit ack_commit);
    logic idle;
    idle = (u == 1);
    for (int i = 0; i < n; i++) begin
      drive(u, idle, bits[63-i], 1'b1);
      repeat (4) @(negedge clk);
      drive(u, ~idle, bits[63-i], 1'b1);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        set_ack(u, ack_commit && (i == FW - 1) && (k == 2));
      end
    end
    drive(u, idle, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input int u, input logic [63:0] bits, input int n,
                            input bit ack_commit, output logic busy_mid);
    logic idle;
    idle = (u == 1);
    @(negedge clk);
    drive(u, idle, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    clock_bits(u, bits, n, ack_commit);
    busy_mid = (u == 0) ? busy0 : busy1;
    drive(u, idle, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        bm;
    int          fe_b, ov_b;
    logic [31:0] m_data;
    bit          m_valid;
    int          nbits, r, e_fe, e_ov;
    bit          ab, ac;
    logic [63:0] val;

    tbl[0] = '{{32'h01020304, 32'h0}, 32, 1'b0, 1'b0, 32'h01020304, 1'b1, 0, 0};
    tbl[1] = '{{32'hABCDE000, 32'h0}, 20, 1'b1, 1'b0, 32'h01020304, 1'b0, 1, 0};
    tbl[2] = '{{32'hDEADBEEF, 2'b11, 30'h0}, 34, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1, 0};
    tbl[3] = '{{32'h11112222, 32'h0}, 32, 1'b1, 1'b0, 32'h11112222, 1'b1, 0, 0};
    tbl[4] = '{{32'h33334444, 32'h0}, 32, 1'b0, 1'b0, 32'h33334444, 1'b1, 0, 1};
    tbl[5] = '{{32'h55556666, 32'h0}, 32, 1'b0, 1'b1, 32'h55556666, 1'b1, 0, 0};
    tbl[6] = '{64'h0, 0, 1'b1, 1'b0, 32'h55556666, 1'b0, 1, 0};
    tbl[7] = '{{32'h00000001, 32'h0}, 32, 1'b1, 1'b0, 32'h00000001, 1'b1, 0, 0};

    repeat (3) @(negedge clk);
    check("rst_data0", data0, 0);
    check("rst_valid0", valid0, 0);
    check("rst_busy0", busy0, 0);
    check("rst_fe0", fe0, 0);
    check("rst_ov0", ov0, 0);
    check("rst_data1", data1, 0);
    check("rst_valid1", valid1, 0);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_busy0", busy0, 0);

    for (int v = 0; v < 8; v++) begin
      fe_b = fe_cnt0; ov_b = ov_cnt0;
      if (tbl[v].ack_before) pulse_ack(0);
      send_frame(0, tbl[v].bits, tbl[v].nbits, tbl[v].ack_commit, bm);
      check($sformatf("vec%0d_data", v), data0, tbl[v].exp_data);
      check($sformatf("vec%0d_valid", v), valid0, tbl[v].exp_valid);
      check($sformatf("vec%0d_frame_err", v), fe_cnt0 - fe_b, tbl[v].exp_fe);
      check($sformatf("vec%0d_overrun", v), ov_cnt0 - ov_b, tbl[v].exp_ov);
      check($sformatf("vec%0d_busy_mid", v), bm, 1);
      check($sformatf("vec%0d_busy_end", v), busy0, 0);
    end

    // Reset in the middle of a frame, released while load stays high.
    fe_b = fe_cnt0; ov_b = ov_cnt0;
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    clock_bits(0, {32'hFFFFFFFF, 32'h0}, 10, 1'b0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_data", data0, 0);
    check("midrst_valid", valid0, 0);
    check("midrst_busy", busy0, 0);
    check("midrst_fe", fe0, 0);
    reset_n = 1'b1;
    clock_bits(0, {32'hFFFFFFFF, 32'h0}, 22, 1'b0);
    check("midrst_ignored_busy", busy0, 0);
    drive(0, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("midrst_no_err", fe_cnt0 - fe_b, 0);
    check("midrst_no_commit_valid", valid0, 0);
    check("midrst_no_commit_data", data0, 0);
    send_frame(0, {32'hA5A55A5A, 32'h0}, 32, 1'b0, bm);
    check("after_rst_data", data0, 32'hA5A55A5A);
    check("after_rst_valid", valid0, 1);
    check("after_rst_fe", fe_cnt0 - fe_b, 0);
    check("after_rst_ov", ov_cnt0 - ov_b, 0);

    // Randomized frames against the frame-level model.
    m_data = 32'hA5A55A5A;
    m_valid = 1'b1;
    for (int t = 0; t < 24; t++) begin
      r = $urandom_range(0, 3);
      nbits = (r == 0) ? $urandom_range(1, 31) : (r == 3) ? $urandom_range(33, 36) : 32;
      val = {$urandom, $urandom};
      ab = 1'($urandom_range(0, 1));
      ac = 1'($urandom_range(0, 1));
      if (ab) m_valid = 1'b0;
      if (nbits >= FW) begin
        e_ov = (m_valid && !ac) ? 1 : 0;
        m_data = val[63:32];
        m_valid = 1'b1;
        e_fe = (nbits > FW) ? 1 : 0;
      end else begin
        e_ov = 0;
        e_fe = 1;
      end
      fe_b = fe_cnt0; ov_b = ov_cnt0;
      if (ab) pulse_ack(0);
      send_frame(0, val, nbits, ac, bm);
      check($sformatf("rnd%0d_n%0d_data", t, nbits), data0, m_data);
      check($sformatf("rnd%0d_n%0d_valid", t, nbits), valid0, m_valid);
      check($sformatf("rnd%0d_n%0d_fe", t, nbits), fe_cnt0 - fe_b, e_fe);
      check($sformatf("rnd%0d_n%0d_ov", t, nbits), ov_cnt0 - ov_b, e_ov);
    end

    // Mode 2 instance: 8-bit words, sampling on falling sck.
    fe_b = fe_cnt1; ov_b = ov_cnt1;
    send_frame(1, {32'hCAFEF00D, 32'h0}, 32, 1'b0, bm);
    check("mode2_data", data1, 32'hCAFEF00D);
    check("mode2_word0", data1[31:24], 8'hCA);
    check("mode2_valid", valid1, 1);
    check("mode2_busy_mid", bm, 1);
    check("mode2_fe", fe_cnt1 - fe_b, 0);
    check("mode2_ov", ov_cnt1 - ov_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
